ai_qram_responder: RTL and testbench
====================================

# ai_qram_responder

Memory-side responder for the comparer's QRAM channel. Accepts packed dual-address requests (two 16-bit word addresses in one 32-bit beat) from the comparer's DMA arbiter. Reads both addresses in parallel from two 32-bit memory banks and returns them as one 64-bit data beat, one cycle after acceptance. A separate write port fills the banks with reference templates before comparison starts.

## Interface
- ADDR_W, 10: bank address width; bank depth is 2**ADDR_W words.
- INIT_ZERO, 1: 1 = banks read as zero until written (simulation/FPGA init); 0 = contents undefined.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  synchronous flush of the request/response pipeline and error flag; bank contents untouched.
- avs_m2_din  in  32  request: [31:16] = high-bank address, [15:0] = low-bank address.
- avs_m2_valid  in  1  request valid.
- avs_m2_ready  out  1  request accepted when valid & ready.
- avm_s2_dout  out  64  response: [63:32] = high-bank word, [31:0] = low-bank word.
- avm_s2_valid  out  1  response valid.
- avm_s2_ready  in  1  response consumed when valid & ready.
- wr_en  in  1  write strobe.
- wr_bank  in  2  bit1 = write high bank, bit0 = write low bank; both set = same word to both.
- wr_addr  in  16  write word address.
- wr_data  in  32  write data.
- oob_err  out  1  sticky: a request or write address had nonzero bits at or above ADDR_W.

## Operation
- Banks: two synchronous-read RAMs, 2**ADDR_W x 32. Only address bits [ADDR_W-1:0] are used. Upper bits are ignored for access and set oob_err.
- Accept (valid & ready): both bank reads launch and the in-flight flag sets. Next cycle the data pair lands in the output register, or in the skid register if the output register is stalled.
- Output stage: output register plus one skid register. Order is strictly preserved, so responses leave in request order.
- Occupancy = out_valid + skid_valid + inflight. avs_m2_ready = (occupancy - (out_valid & avm_s2_ready)) < 2. This is combinational on avm_s2_ready and guarantees no overflow.
- Drain: on avm_s2_ready with out_valid, the skid entry (if any) moves to output. Otherwise the arriving in-flight word moves to output. Otherwise out_valid clears.
- Write/read collision (same bank, same address, same cycle): the read returns the old data (read-before-write).
- Write with wr_bank = 00 is a no-op, but an out-of-range address still sets oob_err.
- init: clears out_valid, skid_valid, inflight, and oob_err. A read accepted in the init cycle is discarded. avs_m2_ready is forced 0 during init. Writes in the init cycle still occur.
- rst: same as init, and additionally clears avm_s2_dout to 0. Bank contents are not reset.

## Timing
- Reset values: avs_m2_ready 0 (forced while rst high), avm_s2_valid 0, avm_s2_dout 0, oob_err 0. The first cycle after rst deasserts has avs_m2_ready = 1.
- Latency: a request accepted at cycle N has its response valid at N+1 when avm_s2_ready was high at N+1. This matches the comparer arbiter's LOAD1/LOAD2 alternation, which samples data exactly one cycle after issuing an address.
- Throughput: one request and one response per cycle sustained while avm_s2_ready = 1.
- Backpressure: with avm_s2_ready held 0, at most two requests are absorbed (output + skid), then avs_m2_ready drops. It reasserts in the same cycle avm_s2_ready returns high.
- avm_s2_dout holds stable while avm_s2_valid & ~avm_s2_ready.
- Write: wr_data is visible to a read accepted in cycle N+1 or later when written in cycle N.
- oob_err sets in the cycle after the offending accept or write, and stays set until rst or init.

## Test plan
- Fill: write high[5]=0xAAAA0005, low[9]=0x55550009. Request 0x00050009 with avm_s2_ready=1 -> next cycle avm_s2_valid=1, dout=0xAAAA000555550009.
- Streaming: requests {k,k} for k=0..15 on consecutive cycles, banks preloaded with word=addr*3 -> 16 back-to-back responses in order, avs_m2_ready never drops.
- Backpressure: hold avm_s2_ready=0 and present 4 requests -> exactly 2 accepted, then avs_m2_ready=0. Release -> 2 responses in order, then the remaining 2 are accepted, with no loss or duplication.
- Collision: old high[3]=0x1, write 0x2 to high[3] in the same cycle a request for {3,3} is accepted -> response [63:32]=0x1. The next request for {3,3} returns 0x2.
- Out-of-range, ADDR_W=10: request 0x04010001 -> reads high[1]/low[1], oob_err=1 the following cycle. Assert init -> oob_err=0.
- Reset mid-operation: two responses stalled, assert rst for 1 cycle -> avm_s2_valid=0, dout=0. After rst, avs_m2_ready=1 and previously written bank data is still readable.

Source files
------------

// File: rtl/ai_qram_responder.sv
// ai_qram_responder: memory-side responder for the comparer's QRAM channel.
// Each request beat carries two 16-bit word addresses. Both banks are read in
// parallel and the pair comes back as one 64-bit beat, valid the cycle after
// acceptance. The output stage is an output register plus one skid register,
// so two responses can be absorbed under backpressure without loss.
module ai_qram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [31:0] avs_m2_din,
  input  logic        avs_m2_valid,
  output logic        avs_m2_ready,
  output logic [63:0] avm_s2_dout,
  output logic        avm_s2_valid,
  input  logic        avm_s2_ready,
  input  logic        wr_en,
  input  logic [1:0]  wr_bank,
  input  logic [15:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        oob_err
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [15:0] IDX_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

  // True when a word address has any bit set at or above ADDR_W.
  function automatic logic addr_oob(input logic [15:0] addr);
    return (addr & ~IDX_MASK) != 16'd0;
  endfunction

  // Bank storage (never reset: templates survive rst and init).
  logic [31:0] mem_hi_q [DEPTH];
  logic [31:0] mem_lo_q [DEPTH];

  // Output stage state.
  logic        out_valid_q,  out_valid_d;
  logic [63:0] out_data_q,   out_data_d;
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_data_q,  skid_data_d;
  logic        oob_err_q,    oob_err_d;

  // Request decode and handshake.
  logic [ADDR_W-1:0] hi_idx_s;
  logic [ADDR_W-1:0] lo_idx_s;
  logic [ADDR_W-1:0] wr_idx_s;
  logic [31:0]       rd_hi_s;
  logic [31:0]       rd_lo_s;
  logic [63:0]       rd_pair_s;
  logic              req_oob_s;
  logic              wr_oob_s;
  logic              drain_s;
  logic              accept_s;
  logic [1:0]        occ_s;
  logic [1:0]        pending_s;

  assign hi_idx_s  = avs_m2_din[16 +: ADDR_W];
  assign lo_idx_s  = avs_m2_din[0 +: ADDR_W];
  assign wr_idx_s  = wr_addr[ADDR_W-1:0];
  assign req_oob_s = addr_oob(avs_m2_din[31:16]) | addr_oob(avs_m2_din[15:0]);
  assign wr_oob_s  = addr_oob(wr_addr);

  // Ready looks ahead at this cycle's drain so a consuming sink never sees a
  // bubble; it is forced low while the pipeline is being flushed.
  assign drain_s      = out_valid_q & avm_s2_ready;
  assign occ_s        = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  assign pending_s    = occ_s - {1'b0, drain_s};
  assign avs_m2_ready = ~rst & ~init & (pending_s < 2'd2);
  assign accept_s     = avs_m2_valid & avs_m2_ready;

  generate
    if (INIT_ZERO) begin : g_init_zero
      logic [DEPTH-1:0] seen_hi_q;
      logic [DEPTH-1:0] seen_lo_q;
      logic             boot_done_q;

      // Per-word written flags: the first reset after configuration marks every
      // word unwritten (flops configure to zero); later resets leave them alone.
      always_ff @(posedge clk) begin
        if (rst && !boot_done_q) begin
          seen_hi_q <= '0;
          seen_lo_q <= '0;
        end else begin
          if (wr_en && wr_bank[1]) seen_hi_q[wr_idx_s] <= 1'b1;
          if (wr_en && wr_bank[0]) seen_lo_q[wr_idx_s] <= 1'b1;
        end
        boot_done_q <= boot_done_q | ~rst;
      end

      assign rd_hi_s = seen_hi_q[hi_idx_s] ? mem_hi_q[hi_idx_s] : 32'd0;
      assign rd_lo_s = seen_lo_q[lo_idx_s] ? mem_lo_q[lo_idx_s] : 32'd0;
    end else begin : g_no_init
      assign rd_hi_s = mem_hi_q[hi_idx_s];
      assign rd_lo_s = mem_lo_q[lo_idx_s];
    end
  endgenerate

  assign rd_pair_s = {rd_hi_s, rd_lo_s};

  // Bank write port; a read of the same word in the same cycle sees old data.
  always_ff @(posedge clk) begin
    if (wr_en && wr_bank[1]) mem_hi_q[wr_idx_s] <= wr_data;
    if (wr_en && wr_bank[0]) mem_lo_q[wr_idx_s] <= wr_data;
  end

  // Output/skid next state: the skid entry is always older than a new read, so
  // it moves to the output first to keep responses in request order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    oob_err_d    = oob_err_q;
    if (init) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      oob_err_d    = 1'b0;
    end else begin
      oob_err_d = oob_err_q | (accept_s & req_oob_s) | (wr_en & wr_oob_s);
      if (drain_s) begin
        if (skid_valid_q) begin
          out_data_d = skid_data_q;
          if (accept_s) begin
            skid_data_d = rd_pair_s;
          end else begin
            skid_valid_d = 1'b0;
          end
        end else if (accept_s) begin
          out_data_d = rd_pair_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (!out_valid_q) begin
        if (accept_s) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_pair_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end else begin
        if (accept_s) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rd_pair_s;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end
    end
  end

  // Output stage registers with synchronous reset; rst also zeroes the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= 64'd0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 64'd0;
      oob_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      oob_err_q    <= oob_err_d;
    end
  end

  assign avm_s2_valid = out_valid_q;
  assign avm_s2_dout  = out_data_q;
  assign oob_err      = oob_err_q;

endmodule

// File: tb/tb_ai_qram_responder.sv
// Directed self-checking bench for ai_qram_responder.
module tb_ai_qram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [31:0] avs_m2_din;
  logic        avs_m2_valid;
  logic        avs_m2_ready;
  logic [63:0] avm_s2_dout;
  logic        avm_s2_valid;
  logic        avm_s2_ready;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        oob_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  ai_qram_responder #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .avs_m2_din   (avs_m2_din),
    .avs_m2_valid (avs_m2_valid),
    .avs_m2_ready (avs_m2_ready),
    .avm_s2_dout  (avm_s2_dout),
    .avm_s2_valid (avm_s2_valid),
    .avm_s2_ready (avm_s2_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .oob_err      (oob_err)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] bank, input logic [15:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_bank = bank;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
    wr_bank = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; avs_m2_din = 32'd0; avs_m2_valid = 1'b0;
    avm_s2_ready = 1'b0; wr_en = 1'b0; wr_bank = 2'b00; wr_addr = 16'd0; wr_data = 32'd0;
    step();
    step();
    check_cnt++;
    if (avs_m2_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", avs_m2_ready);
    else pass_cnt++;
    check_cnt++;
    if (avm_s2_valid !== 1'b0 || avm_s2_dout !== 64'd0)
      $display("FAIL reset_out: valid=%b dout=%h want 0/0", avm_s2_valid, avm_s2_dout);
    else pass_cnt++;
    check_cnt++;
    if (oob_err !== 1'b0) $display("FAIL reset_oob: got %b want 0", oob_err);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", avs_m2_ready);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    write_word(2'b10, 16'd5, 32'hAAAA0005);
    write_word(2'b01, 16'd9, 32'h55550009);
    avm_s2_ready = 1'b1;
    avs_m2_din   = 32'h00050009;
    avs_m2_valid = 1'b1;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== 64'hAAAA000555550009)
      $display("FAIL fill_resp: valid=%b dout=%h want 1/aaaa000555550009", avm_s2_valid, avm_s2_dout);
    else pass_cnt++;
    step();
    check_cnt++;
    if (avm_s2_valid !== 1'b0) $display("FAIL fill_drained: valid=%b want 0", avm_s2_valid);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [63:0] exp;
    for (int k = 0; k < 16; k++) write_word(2'b11, 16'(k), 32'(k * 3));
    avm_s2_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      avs_m2_din   = {16'(i), 16'(i)};
      avs_m2_valid = 1'b1;
      #1;
      check_cnt++;
      if (avs_m2_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, avs_m2_ready);
      else pass_cnt++;
      step();
      exp = {32'(i * 3), 32'(i * 3)};
      check_cnt++;
      if (avm_s2_valid !== 1'b1 || avm_s2_dout !== exp)
        $display("FAIL stream_resp[%0d]: valid=%b dout=%h want 1/%h", i, avm_s2_valid, avm_s2_dout, exp);
      else pass_cnt++;
    end
    avs_m2_valid = 1'b0;
    step();
    check_cnt++;
    if (avm_s2_valid !== 1'b0) $display("FAIL stream_end: valid=%b want 0", avm_s2_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // Requests {4,4},{5,5},{6,6},{7,7}; banks hold addr*3.
    avm_s2_ready = 1'b0;
    avs_m2_din = {16'd4, 16'd4}; avs_m2_valid = 1'b1;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1) $display("FAIL bp_acc0: ready=%b want 1", avs_m2_ready);
    else pass_cnt++;
    step();
    avs_m2_din = {16'd5, 16'd5};
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1 || avm_s2_dout !== {32'd12, 32'd12})
      $display("FAIL bp_acc1: ready=%b dout=%h want 1/%h", avs_m2_ready, avm_s2_dout, {32'd12, 32'd12});
    else pass_cnt++;
    step();
    avs_m2_din = {16'd6, 16'd6};
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b0 || avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd12, 32'd12})
      $display("FAIL bp_full: ready=%b valid=%b dout=%h want 0/1/%h", avs_m2_ready, avm_s2_valid, avm_s2_dout, {32'd12, 32'd12});
    else pass_cnt++;
    step();
    check_cnt++;
    if (avs_m2_ready !== 1'b0 || avm_s2_dout !== {32'd12, 32'd12})
      $display("FAIL bp_hold: ready=%b dout=%h want 0/%h", avs_m2_ready, avm_s2_dout, {32'd12, 32'd12});
    else pass_cnt++;
    avm_s2_ready = 1'b1;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", avs_m2_ready);
    else pass_cnt++;
    step();
    avs_m2_din = {16'd7, 16'd7};
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd15, 32'd15})
      $display("FAIL bp_resp1: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'd15, 32'd15});
    else pass_cnt++;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1) $display("FAIL bp_acc3: ready=%b want 1", avs_m2_ready);
    else pass_cnt++;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd18, 32'd18})
      $display("FAIL bp_resp2: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'd18, 32'd18});
    else pass_cnt++;
    step();
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd21, 32'd21})
      $display("FAIL bp_resp3: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'd21, 32'd21});
    else pass_cnt++;
    step();
    check_cnt++;
    if (avm_s2_valid !== 1'b0) $display("FAIL bp_empty: valid=%b want 0", avm_s2_valid);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    write_word(2'b10, 16'd3, 32'h1);
    avm_s2_ready = 1'b1;
    wr_en = 1'b1; wr_bank = 2'b10; wr_addr = 16'd3; wr_data = 32'h2;
    avs_m2_din = {16'd3, 16'd3}; avs_m2_valid = 1'b1;
    step();
    wr_en = 1'b0; wr_bank = 2'b00;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'h1, 32'd9})
      $display("FAIL coll_old: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'h1, 32'd9});
    else pass_cnt++;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'h2, 32'd9})
      $display("FAIL coll_new: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'h2, 32'd9});
    else pass_cnt++;
    step();
  endtask

  task automatic test_oob();
    avm_s2_ready = 1'b1;
    avs_m2_din = 32'h04010001; avs_m2_valid = 1'b1;
    #1;
    check_cnt++;
    if (oob_err !== 1'b0) $display("FAIL oob_pre: got %b want 0", oob_err);
    else pass_cnt++;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd3, 32'd3} || oob_err !== 1'b1)
      $display("FAIL oob_req: valid=%b dout=%h oob=%b want 1/%h/1", avm_s2_valid, avm_s2_dout, oob_err, {32'd3, 32'd3});
    else pass_cnt++;
    step();
    check_cnt++;
    if (oob_err !== 1'b1) $display("FAIL oob_sticky: got %b want 1", oob_err);
    else pass_cnt++;
    init = 1'b1; avs_m2_din = 32'd0; avs_m2_valid = 1'b1;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b0) $display("FAIL init_ready: got %b want 0", avs_m2_ready);
    else pass_cnt++;
    step();
    init = 1'b0; avs_m2_valid = 1'b0;
    check_cnt++;
    if (oob_err !== 1'b0 || avm_s2_valid !== 1'b0)
      $display("FAIL init_clear: oob=%b valid=%b want 0/0", oob_err, avm_s2_valid);
    else pass_cnt++;
    // A bank-less write with an out-of-range address flags but stores nothing.
    write_word(2'b00, 16'h0400, 32'hDEADBEEF);
    check_cnt++;
    if (oob_err !== 1'b1) $display("FAIL oob_wr_nobank: got %b want 1", oob_err);
    else pass_cnt++;
    avs_m2_din = 32'd0; avs_m2_valid = 1'b1;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== 64'd0)
      $display("FAIL nobank_nowrite: valid=%b dout=%h want 1/0", avm_s2_valid, avm_s2_dout);
    else pass_cnt++;
    init = 1'b1;
    step();
    init = 1'b0;
    check_cnt++;
    if (oob_err !== 1'b0) $display("FAIL init_clear2: got %b want 0", oob_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    avm_s2_ready = 1'b0;
    avs_m2_din = {16'd10, 16'd10}; avs_m2_valid = 1'b1;
    step();
    avs_m2_din = {16'd11, 16'd11};
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avs_m2_ready !== 1'b0)
      $display("FAIL mid_stalled: valid=%b ready=%b want 1/0", avm_s2_valid, avs_m2_ready);
    else pass_cnt++;
    rst = 1'b1;
    step();
    check_cnt++;
    if (avm_s2_valid !== 1'b0 || avm_s2_dout !== 64'd0 || avs_m2_ready !== 1'b0)
      $display("FAIL mid_reset: valid=%b dout=%h ready=%b want 0/0/0", avm_s2_valid, avm_s2_dout, avs_m2_ready);
    else pass_cnt++;
    rst = 1'b0;
    avm_s2_ready = 1'b1;
    #1;
    check_cnt++;
    if (avs_m2_ready !== 1'b1) $display("FAIL mid_ready_after: got %b want 1", avs_m2_ready);
    else pass_cnt++;
    avs_m2_din = {16'd11, 16'd10}; avs_m2_valid = 1'b1;
    step();
    avs_m2_din = {16'd3, 16'd9};
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'd33, 32'd30})
      $display("FAIL mid_keep1: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'd33, 32'd30});
    else pass_cnt++;
    step();
    avs_m2_valid = 1'b0;
    check_cnt++;
    if (avm_s2_valid !== 1'b1 || avm_s2_dout !== {32'h2, 32'd27})
      $display("FAIL mid_keep2: valid=%b dout=%h want 1/%h", avm_s2_valid, avm_s2_dout, {32'h2, 32'd27});
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_backpressure();
    test_collision();
    test_oob();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
